// File: rtl/bus_interconnect_rr.sv
// Shared-bus interconnect: NUM_MASTERS masters to NUM_SLAVES slaves through a round-robin
// arbiter with split-transaction parking, a grant watchdog and a registered-select mux.
module bus_interconnect_rr #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [NUM_MASTERS-1:0]        m_request,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_slave_sel,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]        m_write_en,
  input  logic [NUM_MASTERS-1:0]        m_read_en,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  input  logic [NUM_MASTERS-1:0]        m_trans_done,
  output logic [NUM_MASTERS-1:0]        m_grant,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]        m_slave_valid,
  output logic [NUM_MASTERS-1:0]        m_slave_ready,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [NUM_SLAVES-1:0]         s_valid,
  output logic [NUM_SLAVES-1:0]         s_write_en,
  output logic [NUM_SLAVES-1:0]         s_read_en,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata,
  input  logic [NUM_SLAVES-1:0]         s_slave_valid,
  input  logic [NUM_SLAVES-1:0]         s_slave_ready,
  input  logic [NUM_SLAVES-1:0]         s_split_en,
  output logic [2:0]                    grant_id,
  output logic                          arbiter_busy,
  output logic                          bus_busy,
  output logic                          timeout_err
);

  typedef enum logic [1:0] {StIdle, StActive, StTurn} state_e;

  state_e                      state_q, state_d;
  logic [2:0]                  owner_q, owner_d;
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic [2:0]                  rr_ptr_q, rr_ptr_d;
  logic [NUM_SLAVES-1:0]       park_vld_q, park_vld_d;
  logic [NUM_SLAVES-1:0][2:0]  park_id_q, park_id_d;
  logic [31:0]                 wdog_q, wdog_d;

  logic [NUM_MASTERS-1:0] parked, eligible;
  logic                   resume_found, rr_found;
  logic [2:0]             resume_id, rr_id;
  logic [SEL_W-1:0]       resume_sel, rr_sel;
  logic                   own_valid, own_we, own_re, own_done, own_split;
  logic                   slv_valid, slv_ready;
  logic                   active;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      sel_q      <= '0;
      rr_ptr_q   <= 3'(NUM_MASTERS - 1);
      park_vld_q <= '0;
      park_id_q  <= '0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      park_vld_q <= park_vld_d;
      park_id_q  <= park_id_d;
      wdog_q     <= wdog_d;
    end
  end

  // Arbitration candidates: parked masters whose slave released the split, then round-robin.
  always_comb begin
    parked       = '0;
    eligible     = '0;
    resume_found = 1'b0;
    resume_id    = '0;
    resume_sel   = '0;
    rr_found     = 1'b0;
    rr_id        = '0;
    rr_sel       = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      for (int s = 0; s < int'(NUM_SLAVES); s++) begin
        if (park_vld_q[s] && park_id_q[s] == 3'(i)) begin
          parked[i] = 1'b1;
          if (!resume_found && !s_split_en[s] && m_request[i]) begin
            resume_found = 1'b1;
            resume_id    = 3'(i);
            resume_sel   = SEL_W'(s);
          end
        end
      end
      eligible[i] = m_request[i] && !parked[i] &&
                    (32'(m_slave_sel[i*SEL_W +: SEL_W]) < NUM_SLAVES);
    end
    for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % int'(NUM_MASTERS);
      if (!rr_found && eligible[idx]) begin
        rr_found = 1'b1;
        rr_id    = 3'(idx);
        rr_sel   = m_slave_sel[idx*SEL_W +: SEL_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    park_vld_d = park_vld_q;
    park_id_d  = park_id_q;
    wdog_d     = wdog_q;
    // A parked master that withdraws its request gives up its slot.
    for (int s = 0; s < int'(NUM_SLAVES); s++) begin
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
        if (park_vld_q[s] && park_id_q[s] == 3'(i) && !m_request[i]) park_vld_d[s] = 1'b0;
      end
    end
    unique case (state_q)
      StIdle: begin
        if (resume_found) begin
          state_d = StActive;
          owner_d = resume_id;
          sel_d   = resume_sel;
          wdog_d  = '0;
          for (int s = 0; s < int'(NUM_SLAVES); s++) begin
            if (resume_sel == SEL_W'(s)) park_vld_d[s] = 1'b0;
          end
        end else if (rr_found) begin
          state_d = StActive;
          owner_d = rr_id;
          sel_d   = rr_sel;
          wdog_d  = '0;
        end
      end
      StActive: begin
        wdog_d = wdog_q + 32'd1;
        if (own_done) begin
          state_d  = StTurn;
          rr_ptr_d = owner_q;
        end else if (own_split) begin
          state_d  = StTurn;
          rr_ptr_d = owner_q;
          for (int s = 0; s < int'(NUM_SLAVES); s++) begin
            if (sel_q == SEL_W'(s) && !park_vld_q[s]) begin
              park_vld_d[s] = 1'b1;
              park_id_d[s]  = owner_q;
            end
          end
        end else if (timeout_err) begin
          state_d  = StTurn;
          rr_ptr_d = owner_q;
        end
      end
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Mux is steered only by registered owner/sel, so data paths add no latency.
  always_comb begin
    active        = (state_q == StActive);
    m_grant       = '0;
    m_rdata       = '0;
    m_slave_valid = '0;
    m_slave_ready = '0;
    s_addr        = '0;
    s_wdata       = '0;
    s_valid       = '0;
    s_write_en    = '0;
    s_read_en     = '0;
    own_valid     = 1'b0;
    own_we        = 1'b0;
    own_re        = 1'b0;
    own_done      = 1'b0;
    own_split     = 1'b0;
    slv_valid     = 1'b0;
    slv_ready     = 1'b0;
    if (active) begin
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
        if (owner_q == 3'(i)) begin
          m_grant[i] = 1'b1;
          s_addr     = m_addr[i*ADDR_W +: ADDR_W];
          s_wdata    = m_wdata[i*DATA_W +: DATA_W];
          own_valid  = m_valid[i];
          own_we     = m_write_en[i];
          own_re     = m_read_en[i];
          own_done   = m_trans_done[i];
        end
      end
      for (int s = 0; s < int'(NUM_SLAVES); s++) begin
        if (sel_q == SEL_W'(s)) begin
          s_valid[s]    = own_valid;
          s_write_en[s] = own_we;
          s_read_en[s]  = own_re;
          m_rdata       = s_rdata[s*DATA_W +: DATA_W];
          slv_valid     = s_slave_valid[s];
          slv_ready     = s_slave_ready[s];
          own_split     = s_split_en[s];
        end
      end
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
        if (owner_q == 3'(i)) begin
          m_slave_valid[i] = slv_valid;
          m_slave_ready[i] = slv_ready;
        end
      end
    end
    timeout_err  = active && (TIMEOUT_CYC != 0) && (wdog_q == TIMEOUT_CYC - 1) &&
                   !own_done && !own_split;
    grant_id     = owner_q;
    arbiter_busy = (state_q != StIdle);
    bus_busy     = active;
  end

endmodule

// File: tb/tb_bus_interconnect_rr.sv
// Directed self-checking bench for bus_interconnect_rr (4 masters, 4 slaves, 16-cycle watchdog).
module tb_bus_interconnect_rr;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  m_request, m_write_en, m_read_en, m_valid, m_trans_done;
  logic [11:0] m_slave_sel;
  logic [47:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_grant, m_slave_valid, m_slave_ready;
  logic [7:0]  m_rdata;
  logic [11:0] s_addr;
  logic [7:0]  s_wdata;
  logic [3:0]  s_valid, s_write_en, s_read_en;
  logic [31:0] s_rdata;
  logic [3:0]  s_slave_valid, s_slave_ready, s_split_en;
  logic [2:0]  grant_id;
  logic        arbiter_busy, bus_busy, timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  bus_interconnect_rr #(
    .NUM_MASTERS (4),
    .NUM_SLAVES  (4),
    .ADDR_W      (12),
    .DATA_W      (8),
    .SEL_W       (3),
    .TIMEOUT_CYC (16)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .m_request     (m_request),
    .m_slave_sel   (m_slave_sel),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_write_en    (m_write_en),
    .m_read_en     (m_read_en),
    .m_valid       (m_valid),
    .m_trans_done  (m_trans_done),
    .m_grant       (m_grant),
    .m_rdata       (m_rdata),
    .m_slave_valid (m_slave_valid),
    .m_slave_ready (m_slave_ready),
    .s_addr        (s_addr),
    .s_wdata       (s_wdata),
    .s_valid       (s_valid),
    .s_write_en    (s_write_en),
    .s_read_en     (s_read_en),
    .s_rdata       (s_rdata),
    .s_slave_valid (s_slave_valid),
    .s_slave_ready (s_slave_ready),
    .s_split_en    (s_split_en),
    .grant_id      (grant_id),
    .arbiter_busy  (arbiter_busy),
    .bus_busy      (bus_busy),
    .timeout_err   (timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_request = '0; m_write_en = '0; m_read_en = '0; m_valid = '0; m_trans_done = '0;
    m_slave_sel = '0; m_addr = '0; m_wdata = '0;
    s_rdata = '0; s_slave_valid = '0; s_slave_ready = '0; s_split_en = '0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    clear_inputs();
    step();
    step();
    sys_rst = 1'b1;
  endtask

  task automatic finish_owner(input int m);
    m_trans_done[m] = 1'b1;
    m_request[m]    = 1'b0;
    step();
    m_trans_done[m] = 1'b0;
    step();
  endtask

  initial begin
    int exp_m, cnt, pulses, grants;

    // Reset state
    do_reset();
    check_eq("rst_grant", m_grant, 4'h0);
    check_eq("rst_abusy", arbiter_busy, 1'b0);
    check_eq("rst_bbusy", bus_busy, 1'b0);
    check_eq("rst_gid", grant_id, 3'd0);
    check_eq("rst_svalid", s_valid, 4'h0);

    // Masters 0 and 2 contend; master 0 wins, master 2 follows 2 cycles after trans_done
    m_request = 4'b0101;
    m_slave_sel[0 +: 3] = 3'd1;
    m_slave_sel[6 +: 3] = 3'd3;
    m_valid[0] = 1'b1;
    m_addr[0 +: 12] = 12'h123;
    s_rdata[8 +: 8] = 8'hA5;
    s_slave_ready[1] = 1'b1;
    check_eq("t1_idle_grant", m_grant, 4'h0);
    step();
    check_eq("t1_grant0", m_grant, 4'b0001);
    check_eq("t1_bbusy", bus_busy, 1'b1);
    check_eq("t1_svalid", s_valid, 4'b0010);
    check_eq("t1_saddr", s_addr, 12'h123);
    check_eq("t1_rdata", m_rdata, 8'hA5);
    check_eq("t1_mready", m_slave_ready, 4'b0001);
    m_valid[0] = 1'b0;
    #1;
    check_eq("t1_svalid_follow", s_valid, 4'b0000);
    m_trans_done[0] = 1'b1;
    m_request[0] = 1'b0;
    step();
    m_trans_done[0] = 1'b0;
    check_eq("t1_turn_grant", m_grant, 4'h0);
    check_eq("t1_turn_abusy", arbiter_busy, 1'b1);
    check_eq("t1_turn_bbusy", bus_busy, 1'b0);
    step();
    check_eq("t1_idle_gid_hold", grant_id, 3'd0);
    check_eq("t1_idle_grant2", m_grant, 4'h0);
    step();
    check_eq("t1_grant2", m_grant, 4'b0100);
    check_eq("t1_gid2", grant_id, 3'd2);
    finish_owner(2);

    // All four masters request continuously: order 0,1,2,3,0 with 2-cycle gaps
    do_reset();
    m_request = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_m = g % 4;
      cnt = 0;
      while (m_grant == 4'h0 && cnt < 6) begin
        step();
        cnt++;
      end
      check_eq($sformatf("t2_grant%0d", g), m_grant, 32'(1) << exp_m);
      if (g > 0) check_eq($sformatf("t2_gap%0d", g), cnt, 2);
      step();
      step();
      m_trans_done[exp_m] = 1'b1;
      step();
      m_trans_done[exp_m] = 1'b0;
    end
    m_request = '0;
    step();
    step();

    // Split: master 1 parks on slave 2, master 3 runs, master 1 resumes ahead of master 0
    m_request = 4'b1011;
    m_slave_sel[0 +: 3] = 3'd1;
    m_slave_sel[3 +: 3] = 3'd2;
    m_slave_sel[9 +: 3] = 3'd0;
    m_valid[1] = 1'b1;
    step();
    check_eq("t3_grant1", m_grant, 4'b0010);
    check_eq("t3_svalid2", s_valid, 4'b0100);
    step();
    s_split_en[2] = 1'b1;
    step();
    check_eq("t3_split_drop", m_grant, 4'h0);
    step();
    step();
    check_eq("t3_grant3", m_grant, 4'b1000);
    s_split_en[2] = 1'b0;
    finish_owner(3);
    step();
    check_eq("t3_resume1", m_grant, 4'b0010);
    check_eq("t3_resume_svalid", s_valid, 4'b0100);
    m_valid[1] = 1'b0;
    finish_owner(1);
    step();
    check_eq("t3_grant0", m_grant, 4'b0001);
    finish_owner(0);

    // Watchdog: owner 2 never finishes; pulse on the 16th active cycle only
    m_request = 4'b0100;
    m_slave_sel[6 +: 3] = 3'd1;
    step();
    check_eq("t4_grant2", m_grant, 4'b0100);
    pulses = 0;
    for (int c = 1; c < 16; c++) begin
      if (timeout_err) pulses++;
      if (c < 15) step();
    end
    check_eq("t4_no_early_pulse", pulses, 0);
    step();
    check_eq("t4_pulse", timeout_err, 1'b1);
    check_eq("t4_grant_at_pulse", m_grant, 4'b0100);
    m_request = 4'b1000;
    step();
    check_eq("t4_pulse_end", timeout_err, 1'b0);
    check_eq("t4_turn_grant", m_grant, 4'h0);
    step();
    step();
    check_eq("t4_next_grant3", m_grant, 4'b1000);
    finish_owner(3);

    // Out-of-range select is never granted
    m_request = 4'b0010;
    m_slave_sel[3 +: 3] = 3'd7;
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (m_grant != 4'h0 || arbiter_busy) grants++;
    end
    check_eq("t5_sel7_never", grants, 0);
    m_request[0] = 1'b1;
    m_slave_sel[0 +: 3] = 3'd0;
    step();
    check_eq("t5_other_grant0", m_grant, 4'b0001);
    finish_owner(0);
    step();
    step();
    check_eq("t5_sel7_still", m_grant, 4'h0);
    m_request = '0;

    // Reset during an active transaction
    m_request = 4'b0100;
    m_slave_sel[6 +: 3] = 3'd3;
    m_valid[2] = 1'b1;
    step();
    check_eq("t6_grant2", m_grant, 4'b0100);
    sys_rst = 1'b0;
    step();
    check_eq("t6_rst_grant", m_grant, 4'h0);
    check_eq("t6_rst_svalid", s_valid, 4'h0);
    check_eq("t6_rst_abusy", arbiter_busy, 1'b0);
    check_eq("t6_rst_bbusy", bus_busy, 1'b0);
    sys_rst = 1'b1;
    m_valid = '0;
    m_request = 4'b0011;
    m_slave_sel[0 +: 3] = 3'd0;
    m_slave_sel[3 +: 3] = 3'd0;
    step();
    check_eq("t6_post_rst_grant0", m_grant, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_interconnect_rr.md
Name: bus_interconnect_rr

Overview:
- Parametrised successor to the two-master/three-slave interconnect.
- Connects NUM_MASTERS masters to NUM_SLAVES slaves over one shared bus.
- Contains a round-robin arbiter with split-transaction parking and a transaction watchdog, plus a registered-select address/data/control mux.
- Sits between the master ports and the slave ports in the system bus top level.

Parameters:
- NUM_MASTERS, 4, number of master ports (2..8).
- NUM_SLAVES, 4, number of slave ports (2..8).
- ADDR_W, 12, address width routed to the selected slave.
- DATA_W, 8, write/read data width.
- SEL_W, 3, slave-select field width per master; must satisfy 2^SEL_W >= NUM_SLAVES.
- TIMEOUT_CYC, 1024, maximum cycles a grant may be held without trans_done; 0 disables the watchdog.

Ports:
- sys_clk  in  1  single clock; all logic is on the rising edge.
- sys_rst  in  1  reset, synchronous, active-low.
- m_request  in  NUM_MASTERS  per-master bus request.
- m_slave_sel  in  NUM_MASTERS*SEL_W  per-master target slave index; master i occupies bits [i*SEL_W +: SEL_W].
- m_addr  in  NUM_MASTERS*ADDR_W  per-master address.
- m_wdata  in  NUM_MASTERS*DATA_W  per-master write data.
- m_write_en, m_read_en, m_valid  in  NUM_MASTERS each  per-master control.
- m_trans_done  in  NUM_MASTERS  owner signals end of transaction.
- m_grant  out  NUM_MASTERS  one-hot grant.
- m_rdata  out  DATA_W  read data from the selected slave, broadcast to all masters.
- m_slave_valid, m_slave_ready  out  NUM_MASTERS each  slave handshake, routed to the owner only.
- s_addr  out  ADDR_W  address, shared by all slaves.
- s_wdata  out  DATA_W  write data, shared by all slaves.
- s_valid, s_write_en, s_read_en  out  NUM_SLAVES each  asserted only on the selected slave.
- s_rdata  in  NUM_SLAVES*DATA_W  per-slave read data.
- s_slave_valid, s_slave_ready, s_split_en  in  NUM_SLAVES each  per-slave handshake and split request.
- grant_id  out  3  index of the current owner.
- arbiter_busy  out  1  state != IDLE.
- bus_busy  out  1  state == ACTIVE.
- timeout_err  out  1  one-cycle pulse when the watchdog aborts a transaction.

Behaviour:
- Reset (sys_rst low at an edge): state IDLE; all outputs 0; rr_ptr = NUM_MASTERS-1, so master 0 wins first; split table cleared; watchdog cleared. Reset overrides any in-flight transaction with no completion signalled.
- Eligibility: master i is eligible when m_request[i]=1, its sel < NUM_SLAVES, and it is not parked. Requests with sel >= NUM_SLAVES are never granted.
- State machine has three states: IDLE, ACTIVE, TURN.
- IDLE:
  - If a parked master's slave has dropped s_split_en and that master is requesting, it wins. Among several such masters, the lowest index wins.
  - Otherwise round-robin picks the first eligible master starting at rr_ptr+1, wrapping modulo NUM_MASTERS.
  - The winner's index and sel are registered, m_grant is set, and the state goes to ACTIVE. Grant latency is 1 cycle from request.
- ACTIVE:
  - Mux is driven from the registered owner/sel; it is purely combinational from the registers, so there is zero added data latency.
  - Non-selected slaves see s_valid/s_write_en/s_read_en = 0. Non-owners see m_slave_valid/m_slave_ready = 0.
  - Watchdog counts each cycle.
  - Exits, in priority order: (1) m_trans_done[owner] -> TURN, rr_ptr=owner; (2) s_split_en[sel] -> park owner on sel, TURN, rr_ptr=owner; (3) watchdog reaches TIMEOUT_CYC-1 -> timeout_err pulse, TURN.
  - If trans_done and split_en occur in the same cycle, trans_done wins and nothing is parked.
- TURN: one cycle with all grants and slave strobes 0 (bus turnaround); then IDLE. Back-to-back transactions therefore have a 2-cycle gap between grants.
- Split table: one parked master per slave. A second split on a slave that already has a parked master is not parked: it is treated as a normal completion.
- Parked masters stay excluded from arbitration until their slave's s_split_en deasserts. A parked master that drops m_request is unparked.
- If m_request[owner] drops while ACTIVE without trans_done, the grant is held until trans_done or the watchdog fires.
- grant_id holds the last owner value while IDLE.

Test Plan:
- Masters 0 and 2 request together after reset, sel=1 and 3 -> grant 0 at +1 cycle, s_valid[1] follows m_valid[0]; trans_done -> TURN -> grant 2 exactly 2 cycles after trans_done.
- All four masters request continuously, each asserting trans_done 3 cycles after grant -> grant order 0,1,2,3,0; no master granted twice before the others.
- Master 1 targets slave 2, which raises s_split_en on cycle 2 of ACTIVE -> grant 1 drops, master 3 is granted next; slave 2 drops split_en -> master 1 is granted before round-robin order resumes.
- TIMEOUT_CYC=16, owner never asserts trans_done -> timeout_err is a 1-cycle pulse on the 16th ACTIVE cycle, bus returns to IDLE, next requester is granted.
- m_slave_sel=7 with NUM_SLAVES=4 -> never granted; other masters unaffected.
- sys_rst low mid-ACTIVE -> next edge: all grants, strobes and busy flags 0; after release, master 0 wins a 0/1 contention.
